serial_parity_receiver: RTL and testbench

- Consumes a serial bit stream, such as the output of the team's mux-built XOR gate stage, one bit per accepted handshake.
- Deserializes each frame of DATA_W data bits (LSB first) followed by one parity bit.
- Accumulates running parity with XOR and presents the recovered word plus a parity-error flag to a downstream consumer over a valid/ready handshake.
- Keeps a saturating count of frames that had a parity error.

---
 rtl/serial_parity_receiver_if.sv | 18 +
 rtl/serial_parity_receiver.sv | 63 ++++++
 tb/tb_serial_parity_receiver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_receiver_if.sv
// serial_parity_receiver_if: serial bit input stream and deserialized frame output.
//   in_valid/in_ready/in_bit               serial bit handshake
//   out_valid/out_ready/out_data/out_err   frame handshake
//   err_cnt                                saturating parity-error frame count
interface serial_parity_receiver_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic              in_bit;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [7:0]        err_cnt;
  modport master (output in_valid, in_bit, out_ready,
                  input  in_ready, out_valid, out_data, out_err, err_cnt);
  modport slave  (input  in_valid, in_bit, out_ready,
                  output in_ready, out_valid, out_data, out_err, err_cnt);
endinterface

// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver: deserializes DATA_W LSB-first bits plus a parity bit per frame.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         serial_parity_receiver_if slave: bit input, frame output, error count
module serial_parity_receiver #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input logic clk,
  input logic rst_n,
  serial_parity_receiver_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic {RECV, HOLD} state_t;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              err;
  logic [7:0]        err_cnt;
  logic              xfer, last, new_err;
  always_comb begin
    xfer     = bus.in_valid && state == RECV;
    last     = cnt == CW'(DATA_W);
    new_err  = par ^ bus.in_bit ^ (ODD != 0);
    state_nx = (xfer && last) ? HOLD :
               (state == HOLD && valid && bus.out_ready) ? RECV : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RECV;
      cnt     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      valid   <= 1'b0;
      data    <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      if (xfer && !last) begin
        shreg <= {bus.in_bit, shreg[DATA_W-1:1]};
        par   <= par ^ bus.in_bit;
        cnt   <= cnt + CW'(1);
      end
      if (xfer && last) begin
        data  <= shreg;
        err   <= new_err;
        valid <= 1'b1;
        cnt   <= '0;
        par   <= 1'b0;
        if (new_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
      if (valid && bus.out_ready) valid <= 1'b0;
    end
  end
  assign bus.in_ready  = state == RECV;
  assign bus.out_valid = valid;
  assign bus.out_data  = data;
  assign bus.out_err   = err;
  assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_serial_parity_receiver.sv
// tb_serial_parity_receiver: even and odd parity receivers driven in lockstep against a frame-level model.
module tb_serial_parity_receiver;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic out_ready = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  serial_parity_receiver_if #(.DATA_W(DW)) e_if ();
  serial_parity_receiver_if #(.DATA_W(DW)) o_if ();
  assign e_if.in_valid  = in_valid;
  assign e_if.in_bit    = in_bit;
  assign e_if.out_ready = out_ready;
  assign o_if.in_valid  = in_valid;
  assign o_if.in_bit    = in_bit;
  assign o_if.out_ready = out_ready;
  serial_parity_receiver #(.DATA_W(DW), .ODD(0)) u_even (.clk(clk), .rst_n(rst_n), .bus(e_if.slave));
  serial_parity_receiver #(.DATA_W(DW), .ODD(1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(o_if.slave));
  logic          q[$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_err_e;
  int            m_cnt_e, m_cnt_o;
  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
    logic       err_e;
    int         cnt_e;
    int         cnt_o;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_err_e = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
  endtask
  task automatic model_step(input logic v, input logic b, input logic r);
    int ones;
    if (m_valid) begin
      if (r) m_valid = 1'b0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() == DW + 1) begin
        ones = 0;
        for (int i = 0; i <= DW; i++) ones += int'(q[i]);
        for (int i = 0; i < DW; i++) m_data[i] = q[i];
        m_err_e = (ones % 2) == 1;
        if (m_err_e) m_cnt_e = m_cnt_e < 255 ? m_cnt_e + 1 : 255;
        else         m_cnt_o = m_cnt_o < 255 ? m_cnt_o + 1 : 255;
        m_valid = 1'b1;
        q.delete();
      end
    end
  endtask
  task automatic compare_all();
    chk("e_in_ready",  e_if.in_ready,  !m_valid);
    chk("o_in_ready",  o_if.in_ready,  !m_valid);
    chk("e_out_valid", e_if.out_valid, m_valid);
    chk("o_out_valid", o_if.out_valid, m_valid);
    chk("e_err_cnt",   e_if.err_cnt,   m_cnt_e);
    chk("o_err_cnt",   o_if.err_cnt,   m_cnt_o);
    if (m_valid) begin
      chk("e_out_data", e_if.out_data, m_data);
      chk("o_out_data", o_if.out_data, m_data);
      chk("e_out_err",  e_if.out_err,  m_err_e);
      chk("o_out_err",  o_if.out_err,  !m_err_e);
    end
  endtask
  task automatic cycle();
    logic v, b, r;
    v = in_valid;
    b = in_bit;
    r = out_ready;
    @(posedge clk);
    #1;
    model_step(v, b, r);
    compare_all();
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
    for (int i = 0; i <= DW; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        cycle();
      end
      in_valid = 1'b1;
      in_bit   = i < DW ? d[i] : p;
      cycle();
    end
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_e_out_valid", e_if.out_valid, 0);
    chk("rst_o_out_valid", o_if.out_valid, 0);
    chk("rst_e_err_cnt",   e_if.err_cnt,   0);
    chk("rst_o_err_cnt",   o_if.err_cnt,   0);
    chk("rst_e_in_ready",  e_if.in_ready,  1);
    chk("rst_e_out_data",  e_if.out_data,  0);
    chk("rst_e_out_err",   e_if.out_err,   0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] d;
    tbl[0] = '{8'hA5, 1'b0, 0, 1'b0, 0, 1};
    tbl[1] = '{8'hA5, 1'b1, 0, 1'b1, 1, 1};
    tbl[2] = '{8'h81, 1'b0, 2, 1'b0, 1, 2};
    tbl[3] = '{8'h01, 1'b0, 0, 1'b1, 2, 2};
    tbl[4] = '{8'h03, 1'b0, 0, 1'b0, 2, 3};
    tbl[5] = '{8'h0F, 1'b0, 0, 1'b0, 2, 4};
    tbl[6] = '{8'hFF, 1'b1, 0, 1'b1, 3, 4};
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;
    foreach (tbl[k]) begin
      send_frame(tbl[k].data, tbl[k].par, tbl[k].gap);
      chk("tbl_out_valid", e_if.out_valid, 1);
      chk("tbl_out_data",  e_if.out_data,  tbl[k].data);
      chk("tbl_e_err",     e_if.out_err,   tbl[k].err_e);
      chk("tbl_o_err",     o_if.out_err,   !tbl[k].err_e);
      chk("tbl_e_cnt",     e_if.err_cnt,   tbl[k].cnt_e);
      chk("tbl_o_cnt",     o_if.err_cnt,   tbl[k].cnt_o);
      cycle();
      chk("tbl_drop",      e_if.out_valid, 0);
    end
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      cycle();
      chk("bp_out_valid", e_if.out_valid, 1);
      chk("bp_out_data",  e_if.out_data,  8'h3C);
      chk("bp_in_ready",  e_if.in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("bp_release", e_if.out_valid, 0);
    send_frame(8'h0F, 1'b0, 0);
    chk("bp_next_data", e_if.out_data, 8'h0F);
    chk("bp_next_err",  e_if.out_err,  0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      cycle();
    end
    do_reset();
    send_frame(8'h55, 1'b0, 0);
    chk("rst_next_data", e_if.out_data, 8'h55);
    chk("rst_next_err",  e_if.out_err,  0);
    cycle();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_bit    = 1'($urandom);
      out_ready = 1'($urandom);
      cycle();
    end
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      d = 8'($urandom);
      send_frame(d, ~(^d), 0);
      chk("sat_e_err", e_if.out_err, 1);
      cycle();
    end
    chk("sat_e_cnt", e_if.err_cnt, 255);
    chk("sat_o_cnt", o_if.err_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
